// File: rtl/dtc_share_sched_if.sv
// Requester, classifier and response signals of the shared decision-tree scheduler.
interface dtc_share_sched_if #(
  parameter int N_REQ = 4,
  parameter int IN_W  = 12,
  parameter int OUT_W = 3
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ-1:0]      req_ready;
  logic [N_REQ*IN_W-1:0] req_feat;
  logic [IN_W-1:0]       dt_inp;
  logic [OUT_W-1:0]      dt_outp;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [OUT_W-1:0]      rsp_class;
  logic [ID_W-1:0]       rsp_id;

  modport master (
    output req_valid, req_feat, dt_outp, rsp_ready,
    input  req_ready, dt_inp, rsp_valid, rsp_class, rsp_id
  );

  modport slave (
    input  req_valid, req_feat, dt_outp, rsp_ready,
    output req_ready, dt_inp, rsp_valid, rsp_class, rsp_id
  );
endinterface

// File: rtl/dtc_share_sched.sv
// Round-robin time-sharing of one combinational classifier among N_REQ requesters;
// the feature is registered, held SETTLE cycles, then the class is returned with its owner ID.
module dtc_share_sched #(
  parameter int N_REQ  = 4,
  parameter int IN_W   = 12,
  parameter int OUT_W  = 3,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  dtc_share_sched_if.slave bus,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);
  localparam int ID_W = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] id_q;
  logic [ID_W-1:0] win;
  logic            found;
  logic [2:0]      settle_cnt;
  int unsigned     idx;

  // Search starts at rr_ptr and wraps, so a non-valid pointer target is skipped
  // while rotation order is preserved.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (!rst && state == IDLE && found) bus.req_ready[win] = 1'b1;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      id_q          <= '0;
      settle_cnt    <= '0;
      bus.dt_inp    <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_class <= '0;
      bus.rsp_id    <= '0;
      done_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            bus.dt_inp <= bus.req_feat[win*IN_W +: IN_W];
            id_q       <= win;
            rr_ptr     <= (win == ID_W'(N_REQ - 1)) ? '0 : win + ID_W'(1);
            settle_cnt <= 3'(SETTLE - 1);
            state      <= EVAL;
          end
        end
        EVAL: begin
          if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - 3'd1;
          end else begin
            bus.rsp_class <= bus.dt_outp;
            bus.rsp_id    <= id_q;
            bus.rsp_valid <= 1'b1;
            state         <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            if (done_cnt != '1) done_cnt <= done_cnt + CNT_W'(1);
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dtc_share_sched.sv
// Directed bench: SETTLE=1 instance for grant/rotation/backpressure, SETTLE=3/CNT_W=2 instance
// for abort-on-reset and counter saturation.
module tb_dtc_share_sched;
  logic        clk = 1'b0;
  logic        rst;
  logic        rst1;
  logic        busy0, busy1;
  logic [15:0] done0;
  logic [1:0]  done1;
  logic [2:0]  pert0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  dtc_share_sched_if #(.N_REQ(4), .IN_W(12), .OUT_W(3)) if0 ();
  dtc_share_sched_if #(.N_REQ(4), .IN_W(12), .OUT_W(3)) if1 ();

  dtc_share_sched #(.N_REQ(4), .IN_W(12), .OUT_W(3), .SETTLE(1), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .bus(if0.slave), .busy(busy0), .done_cnt(done0)
  );

  dtc_share_sched #(.N_REQ(4), .IN_W(12), .OUT_W(3), .SETTLE(3), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst1), .bus(if1.slave), .busy(busy1), .done_cnt(done1)
  );

  // Small decision tree standing in for the shared classifier.
  function automatic logic [2:0] cls(input logic [11:0] f);
    if (f[11]) return (f[3:0] > 4'hB) ? 3'b110 : 3'b101;
    else       return (f[7:4] > 4'h7) ? 3'b011 : 3'b001;
  endfunction

  assign if0.dt_outp = cls(if0.dt_inp) ^ pert0;
  assign if1.dt_outp = cls(if1.dt_inp);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic pulse_rst0();
    adv(); rst = 1'b1;
    adv(); rst = 1'b0;
  endtask

  logic [11:0] fv[4]   = '{12'h80C, 12'h0A0, 12'h801, 12'h010};
  logic [2:0]  cexp[4] = '{3'b110, 3'b011, 3'b101, 3'b001};

  initial begin
    rst = 1'b1; rst1 = 1'b1; pert0 = '0;
    if0.req_valid = '0; if0.req_feat = '0; if0.rsp_ready = 1'b0;
    if1.req_valid = '0; if1.req_feat = '0; if1.rsp_ready = 1'b0;

    // Reset holds req_ready low even with requests pending.
    if0.req_valid = 4'b1111;
    #1 chk("rst_rdy", 32'(if0.req_ready), 0);
    if0.req_valid = '0;
    adv(); adv(); rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      smp();
      chk("idle_rdy", 32'(if0.req_ready), 0);
      chk("idle_dt", 32'(if0.dt_inp), 0);
      chk("idle_rsp", 32'({if0.rsp_valid, if0.rsp_class, if0.rsp_id, busy0}), 0);
      chk("idle_cnt", 32'(done0), 0);
    end

    // Single request from requester 2.
    adv();
    if0.req_feat[2*12 +: 12] = 12'hA5C; if0.req_valid = 4'b0100; if0.rsp_ready = 1'b1;
    smp();
    chk("t2_rdy", 32'(if0.req_ready), 32'h4);
    chk("t2_busy0", 32'(busy0), 0);
    adv(); if0.req_valid = '0;
    smp();
    chk("t2_dt", 32'(if0.dt_inp), 32'hA5C);
    chk("t2_rv0", 32'(if0.rsp_valid), 0);
    chk("t2_busy1", 32'(busy0), 1);
    chk("t2_rdy0", 32'(if0.req_ready), 0);
    adv(); smp();
    chk("t2_rv1", 32'(if0.rsp_valid), 1);
    chk("t2_cls", 32'(if0.rsp_class), 32'h6);
    chk("t2_id", 32'(if0.rsp_id), 2);
    chk("t2_cnt0", 32'(done0), 0);
    adv(); smp();
    chk("t2_cnt1", 32'(done0), 1);
    chk("t2_rvd", 32'(if0.rsp_valid), 0);
    chk("t2_idle", 32'(busy0), 0);
    chk("t2_hold", 32'(if0.dt_inp), 32'hA5C);

    // All requesters valid: grants rotate every 3 cycles.
    pulse_rst0();
    for (int i = 0; i < 4; i++) if0.req_feat[i*12 +: 12] = fv[i];
    if0.req_valid = 4'b1111;
    for (int c = 0; c < 15; c++) begin
      smp();
      chk("t3_rdy", 32'(if0.req_ready), (c % 3 == 0) ? (32'h1 << ((c / 3) % 4)) : 0);
      if (c % 3 == 2) begin
        chk("t3_rv", 32'(if0.rsp_valid), 1);
        chk("t3_id", 32'(if0.rsp_id), (c / 3) % 4);
        chk("t3_cls", 32'(if0.rsp_class), 32'(cexp[(c / 3) % 4]));
      end
    end
    adv(); if0.req_valid = '0;

    // Pointer at 2 after granting 1; requesters 2,3 idle are skipped.
    pulse_rst0();
    if0.req_valid = 4'b0010;
    smp(); chk("t4_rdy1", 32'(if0.req_ready), 32'h2);
    adv(); if0.req_valid = 4'b0011;
    smp(); adv(); smp();
    chk("t4_id1", 32'(if0.rsp_id), 1);
    adv(); smp(); chk("t4_rdy0", 32'(if0.req_ready), 32'h1);
    adv(); smp(); adv(); smp();
    chk("t4_id0", 32'(if0.rsp_id), 0);
    adv(); smp(); chk("t4_rdy1b", 32'(if0.req_ready), 32'h2);
    adv(); if0.req_valid = '0;

    // Backpressure with a changing classifier output.
    pulse_rst0();
    if0.rsp_ready = 1'b0;
    if0.req_feat[3*12 +: 12] = 12'h3F0; if0.req_valid = 4'b1000;
    smp(); chk("t5_rdy", 32'(if0.req_ready), 32'h8);
    adv(); if0.req_valid = '0;
    smp(); adv(); smp();
    chk("t5_rv", 32'(if0.rsp_valid), 1);
    chk("t5_cls", 32'(if0.rsp_class), 32'h3);
    chk("t5_id", 32'(if0.rsp_id), 3);
    for (int k = 0; k < 5; k++) begin
      adv();
      if (k == 0) begin pert0 = 3'b111; if0.req_valid = 4'b1111; end
      smp();
      chk("t5_bp_cls", 32'(if0.rsp_class), 32'h3);
      chk("t5_bp_id", 32'(if0.rsp_id), 3);
      chk("t5_bp_rv", 32'(if0.rsp_valid), 1);
      chk("t5_bp_rdy", 32'(if0.req_ready), 0);
      chk("t5_bp_cnt", 32'(done0), 0);
    end
    adv(); if0.rsp_ready = 1'b1;
    smp();
    chk("t5_hs_rdy", 32'(if0.req_ready), 0);
    chk("t5_hs_rv", 32'(if0.rsp_valid), 1);
    adv(); smp();
    chk("t5_cnt", 32'(done0), 1);
    chk("t5_rvd", 32'(if0.rsp_valid), 0);
    chk("t5_next", 32'(if0.req_ready), 32'h1);
    adv(); if0.req_valid = '0; pert0 = '0;

    // SETTLE=3, CNT_W=2: five completions saturate at 3.
    adv(); rst1 = 1'b0; if1.rsp_ready = 1'b1;
    if1.req_feat[1*12 +: 12] = 12'h0A0;
    for (int n = 1; n <= 5; n++) begin
      adv(); if1.req_valid = 4'b0010;
      smp(); chk("t6_rdy", 32'(if1.req_ready), 32'h2);
      adv(); if1.req_valid = '0;
      smp(); adv(); smp(); adv(); smp();
      chk("t6_rv0", 32'(if1.rsp_valid), 0);
      adv(); smp();
      chk("t6_rv1", 32'(if1.rsp_valid), 1);
      chk("t6_id", 32'(if1.rsp_id), 1);
      chk("t6_cls", 32'(if1.rsp_class), 32'h3);
      adv(); smp();
      chk("t6_cnt", 32'(done1), (n > 3) ? 3 : n);
      chk("t6_idle", 32'(busy1), 0);
    end

    // Reset during the second EVAL cycle aborts the transaction.
    adv(); if1.req_feat[2*12 +: 12] = 12'h801; if1.req_valid = 4'b0100;
    smp(); chk("t6a_rdy", 32'(if1.req_ready), 32'h4);
    adv(); if1.req_valid = '0;
    smp();
    chk("t6a_busy", 32'(busy1), 1);
    chk("t6a_rv", 32'(if1.rsp_valid), 0);
    adv(); rst1 = 1'b1; if1.req_valid = 4'b1111;
    #1;
    chk("t6a_rst_rv", 32'(if1.rsp_valid), 0);
    chk("t6a_rst_busy", 32'(busy1), 0);
    chk("t6a_rst_cnt", 32'(done1), 0);
    chk("t6a_rst_rdy", 32'(if1.req_ready), 0);
    smp(); adv(); smp();
    chk("t6a_rst_rv2", 32'(if1.rsp_valid), 0);
    adv(); rst1 = 1'b0;
    smp();
    chk("t6a_ptr", 32'(if1.req_ready), 32'h1);
    chk("t6a_cnt", 32'(done1), 0);
    chk("t6a_rv3", 32'(if1.rsp_valid), 0);
    adv(); if1.req_valid = '0;
    smp(); chk("t6a_busy2", 32'(busy1), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
